// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU requests, issues them with exact ALU timing (bubble after multiply),
// captures results at the computed edge and returns them tagged, in order.
module alu_issue_ctrl #(
    parameter int N         = 8,
    parameter int TW        = 4,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [N-1:0]    IN_OPA,
    input  logic [N-1:0]    IN_OPB,
    input  logic            IN_CIN,
    input  logic            IN_MODE,
    input  logic [3:0]      IN_CMD,
    input  logic [1:0]      IN_INP_VALID,
    input  logic [TW-1:0]   IN_TAG,
    output logic [N-1:0]    ALU_OPA,
    output logic [N-1:0]    ALU_OPB,
    output logic            ALU_CIN,
    output logic            ALU_MODE,
    output logic [3:0]      ALU_CMD,
    output logic [1:0]      ALU_INP_VALID,
    output logic            ALU_CE,
    input  logic [2*N:0]    ALU_RES,
    input  logic [6:0]      ALU_FLAGS,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [2*N:0]    OUT_RES,
    output logic [6:0]      OUT_FLAGS,
    output logic [TW-1:0]   OUT_TAG
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int QW  = 2*N + 8 + TW;
    localparam int PW  = 2*N + 8 + TW;
    localparam logic [CAW:0]   C_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0]   R_FULL = (RAW+1)'(RES_DEPTH);
    localparam logic [RAW+1:0] R_LIM  = (RAW+2)'(RES_DEPTH);

    logic [QW-1:0]  cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wp, cmd_rp;
    logic [CAW:0]   cmd_cnt;
    logic [PW-1:0]  res_mem [RES_DEPTH];
    logic [RAW-1:0] res_wp, res_rp;
    logic [RAW:0]   res_cnt, inflight;
    logic           live, bubble;
    logic [3:0]     p_v, p_mul;
    logic [3:0][TW-1:0] p_tag;

    logic [N-1:0]  h_opa, h_opb;
    logic          h_cin, h_mode, h_mul;
    logic [3:0]    h_cmd;
    logic [1:0]    h_iv;
    logic [TW-1:0] h_tag, cap_tag;
    logic          push_in, issue, cap, pop;

    assign {h_opa, h_opb, h_cin, h_mode, h_cmd, h_iv, h_tag} = cmd_mem[cmd_rp];
    assign h_mul    = h_mode && h_iv == 2'b11 && (h_cmd == 4'b1001 || h_cmd == 4'b1010);
    assign IN_READY = live && cmd_cnt != C_FULL;
    assign push_in  = IN_VALID && IN_READY;
    assign issue    = cmd_cnt != '0 && !bubble && ({1'b0, inflight} + {1'b0, res_cnt}) < R_LIM;
    // non-multiply results land 3 edges after issue (stage 2), multiplies 4 edges (stage 3)
    assign cap      = (p_v[2] && !p_mul[2]) || (p_v[3] && p_mul[3]);
    assign cap_tag  = (p_v[3] && p_mul[3]) ? p_tag[3] : p_tag[2];
    assign OUT_VALID = res_cnt != '0;
    assign pop       = OUT_VALID && OUT_READY;
    assign {OUT_RES, OUT_FLAGS, OUT_TAG} = OUT_VALID ? res_mem[res_rp] : '0;
    assign ALU_CE    = live;

    always_ff @(posedge CLK) begin
        if (push_in) cmd_mem[cmd_wp] <= {IN_OPA, IN_OPB, IN_CIN, IN_MODE, IN_CMD, IN_INP_VALID, IN_TAG};
        if (cap) res_mem[res_wp] <= {ALU_RES, ALU_FLAGS, cap_tag};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            live          <= 1'b0;
            bubble        <= 1'b0;
            cmd_wp        <= '0;
            cmd_rp        <= '0;
            cmd_cnt       <= '0;
            res_wp        <= '0;
            res_rp        <= '0;
            res_cnt       <= '0;
            inflight      <= '0;
            p_v           <= '0;
            p_mul         <= '0;
            p_tag         <= '0;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            ALU_CIN       <= 1'b0;
            ALU_MODE      <= 1'b0;
            ALU_CMD       <= '0;
            ALU_INP_VALID <= '0;
        end else begin
            live          <= 1'b1;
            bubble        <= issue && h_mul;
            cmd_wp        <= cmd_wp + CAW'(push_in);
            cmd_rp        <= cmd_rp + CAW'(issue);
            cmd_cnt       <= cmd_cnt + (CAW+1)'(push_in) - (CAW+1)'(issue);
            res_wp        <= res_wp + RAW'(cap);
            res_rp        <= res_rp + RAW'(pop);
            res_cnt       <= res_cnt + (RAW+1)'(cap) - (RAW+1)'(pop);
            inflight      <= inflight + (RAW+1)'(issue) - (RAW+1)'(cap);
            p_v           <= {p_v[2:0], issue};
            p_mul         <= {p_mul[2:0], issue && h_mul};
            p_tag         <= {p_tag[2:0], h_tag};
            ALU_OPA       <= issue ? h_opa : '0;
            ALU_OPB       <= issue ? h_opb : '0;
            ALU_CIN       <= issue && h_cin;
            ALU_MODE      <= issue && h_mode;
            ALU_CMD       <= issue ? h_cmd : '0;
            ALU_INP_VALID <= issue ? h_iv : '0;
        end
    end

    // credits guarantee a free result slot at every capture
    always_ff @(posedge CLK)
        if (RST) assert (!(cap && res_cnt == R_FULL && !pop));
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of the issue controller against a
// transaction-level scoreboard and a bench-side ALU that answers at the ALU's own latency.
module tb_alu_issue_ctrl;
    logic        CLK = 1'b0, RST = 1'b0;
    logic        IN_VALID, IN_READY, IN_CIN, IN_MODE;
    logic [7:0]  IN_OPA, IN_OPB;
    logic [3:0]  IN_CMD, IN_TAG;
    logic [1:0]  IN_INP_VALID;
    logic [7:0]  ALU_OPA, ALU_OPB;
    logic        ALU_CIN, ALU_MODE, ALU_CE;
    logic [3:0]  ALU_CMD;
    logic [1:0]  ALU_INP_VALID;
    logic [16:0] ALU_RES, OUT_RES;
    logic [6:0]  ALU_FLAGS, OUT_FLAGS;
    logic        OUT_VALID, OUT_READY;
    logic [3:0]  OUT_TAG;

    alu_issue_ctrl dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OPA(IN_OPA), .IN_OPB(IN_OPB),
        .IN_CIN(IN_CIN), .IN_MODE(IN_MODE), .IN_CMD(IN_CMD), .IN_INP_VALID(IN_INP_VALID),
        .IN_TAG(IN_TAG),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN), .ALU_MODE(ALU_MODE),
        .ALU_CMD(ALU_CMD), .ALU_INP_VALID(ALU_INP_VALID), .ALU_CE(ALU_CE),
        .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RES(OUT_RES),
        .OUT_FLAGS(OUT_FLAGS), .OUT_TAG(OUT_TAG)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    int cyc = 0, acc = 0, iss = 0, dlv = 0;
    logic        nv, ncin, nmode, nrdy, hs_in, hs_out, prev_mul;
    logic [7:0]  na, nb;
    logic [3:0]  ncmd, ntag, tag_ctr;
    logic [1:0]  niv;
    logic [27:0] expq [$];
    logic [23:0] pend_d [16];
    logic        pend_v [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {res[16:0], flags{COUT,OFLOW,G,L,E,ERR,overflow}}; iv[0] = A valid, iv[1] = B valid
    function automatic logic [23:0] alu_ref(input logic m, input logic [3:0] c, input logic [1:0] iv,
                                            input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [16:0] r;
        logic [6:0]  f;
        logic [7:0]  t;
        logic        need_a, need_b;
        r = '0;
        f = '0;
        t = '0;
        need_a = !(m ? (c == 6 || c == 7) : c == 7);
        need_b = !(m ? (c == 4 || c == 5) : c == 6);
        if ((m ? c > 10 : c > 7) || (need_a && !iv[0]) || (need_b && !iv[1])) f[1] = 1'b1;
        else if (m) begin
            case (c)
                0: r = {9'b0, a} + {9'b0, b};
                1: begin t = a - b; r = {9'b0, t}; end
                2: r = {9'b0, a} + {9'b0, b} + {16'b0, ci};
                3: begin t = a - b - {7'b0, ci}; r = {9'b0, t}; end
                4: r = {9'b0, a} + 17'd1;
                5: begin t = a - 8'd1; r = {9'b0, t}; end
                6: r = {9'b0, b} + 17'd1;
                7: begin t = b - 8'd1; r = {9'b0, t}; end
                8: f[4:2] = {a > b, a < b, a == b};
                9: r = ({9'b0, a} + 17'd1) * ({9'b0, b} + 17'd1);
                default: begin t = {a[6:0], 1'b0}; r = {9'b0, t} * {9'b0, b}; end
            endcase
            f[6] = (c == 0 || c == 2) && r[8];
            f[5] = (c == 1 && a < b) || (c == 3 && {1'b0, a} < {1'b0, b} + {8'b0, ci});
        end else begin
            t = c == 0 ? a & b : c == 1 ? ~(a & b) : c == 2 ? a | b : c == 3 ? ~(a | b) :
                c == 4 ? a ^ b : c == 5 ? ~(a ^ b) : c == 6 ? ~a : ~b;
            r = {9'b0, t};
        end
        return {r, f};
    endfunction

    task automatic step();
        int slot;
        logic is_mul;
        logic [27:0] e;
        @(posedge CLK);
        #1;
        cyc++;
        if (hs_in) acc++;
        if (hs_out) dlv++;
        if (prev_mul) check("bubble_after_mul", ALU_INP_VALID, 2'b00);
        is_mul = ALU_MODE && ALU_INP_VALID == 2'b11 && (ALU_CMD == 4'd9 || ALU_CMD == 4'd10);
        if (ALU_INP_VALID != 2'b00) begin
            iss++;
            slot = (cyc + (is_mul ? 4 : 3)) % 16;
            pend_v[slot] = 1'b1;
            pend_d[slot] = alu_ref(ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CIN);
        end
        prev_mul = is_mul;
        check("alu_ce", ALU_CE, 1);
        check("in_ready", IN_READY, (acc - iss) < 4);
        check("credit", (iss - dlv) <= 4, 1);
        slot = (cyc + 1) % 16;
        if (pend_v[slot]) begin
            {ALU_RES, ALU_FLAGS} = pend_d[slot];
            pend_v[slot] = 1'b0;
        end else {ALU_RES, ALU_FLAGS} = 24'($urandom);
        IN_VALID = nv; IN_OPA = na; IN_OPB = nb; IN_CIN = ncin; IN_MODE = nmode;
        IN_CMD = ncmd; IN_INP_VALID = niv; IN_TAG = ntag; OUT_READY = nrdy;
        hs_in = IN_VALID && IN_READY;
        if (hs_in) expq.push_back({alu_ref(nmode, ncmd, niv, na, nb, ncin), ntag});
        hs_out = OUT_VALID && OUT_READY;
        if (hs_out) begin
            if (expq.size() == 0) check("spurious_out", 1, 0);
            else begin
                e = expq.pop_front();
                check("out_res", OUT_RES, e[27:11]);
                check("out_flags", OUT_FLAGS, e[10:4]);
                check("out_tag", OUT_TAG, e[3:0]);
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_alu_ce", ALU_CE, 0);
        check("rst_in_ready", IN_READY, 0);
        check("rst_alu_iv", ALU_INP_VALID, 0);
        expq.delete();
        acc = 0; iss = 0; dlv = 0;
        hs_in = 1'b0; hs_out = 1'b0; prev_mul = 1'b0;
        for (int i = 0; i < 16; i++) pend_v[i] = 1'b0;
        nv = 1'b0; nrdy = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        step();
    endtask

    task automatic send(input logic m, input logic [3:0] c, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [3:0] tg);
        nv = 1'b1; nmode = m; ncmd = c; niv = iv; na = a; nb = b; ncin = ci; ntag = tg;
        step();
        for (int i = 0; i < 200 && !hs_in; i++) step();
        check("send_accepted", hs_in, 1);
        nv = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [16:0] r, input logic [6:0] f,
                            input logic [3:0] tg, output int at);
        nrdy = 1'b1;
        for (int i = 0; i < 50 && !(OUT_VALID && OUT_READY); i++) step();
        at = cyc;
        check({nm, "_valid"}, OUT_VALID, 1);
        check({nm, "_res"}, OUT_RES, r);
        check({nm, "_flags"}, OUT_FLAGS, f);
        check({nm, "_tag"}, OUT_TAG, tg);
        step();
    endtask

    task automatic drain();
        nv = 1'b0;
        nrdy = 1'b1;
        for (int i = 0; i < 400 && expq.size() != 0; i++) step();
        check("drain_left", expq.size(), 0);
    endtask

    initial begin
        int k, at;
        IN_VALID = 0; IN_OPA = 0; IN_OPB = 0; IN_CIN = 0; IN_MODE = 0; IN_CMD = 0;
        IN_INP_VALID = 0; IN_TAG = 0; OUT_READY = 0; ALU_RES = 0; ALU_FLAGS = 0;
        na = 0; nb = 0; ncin = 0; nmode = 0; ncmd = 0; niv = 0; ntag = 0; tag_ctr = 0;
        do_reset();

        nrdy = 1'b1;
        send(1, 4'd0, 2'b11, 8'h0F, 8'h01, 0, 4'd3);
        k = -100;
        for (int i = 0; i < 20 && k < 0; i++) begin
            step();
            if (ALU_INP_VALID != 2'b00) k = cyc;
        end
        wait_out("t1_add", 17'h010, 7'b0, 4'd3, at);
        check("t1_latency", at - k, 3);

        send(1, 4'd9, 2'b11, 8'd2, 8'd3, 0, 4'd1);
        send(1, 4'd0, 2'b11, 8'd5, 8'd6, 0, 4'd2);
        wait_out("t2_mul", 17'd12, 7'b0, 4'd1, at);
        wait_out("t2_add", 17'd11, 7'b0, 4'd2, at);

        send(1, 4'd8, 2'b11, 8'd5, 8'd9, 0, 4'd5);
        wait_out("t5_cmp", 17'd0, 7'b0001000, 4'd5, at);
        send(1, 4'd4, 2'b10, 8'hFF, 8'h00, 0, 4'd6);
        wait_out("t5_inc_err", 17'd0, 7'b0000010, 4'd6, at);
        drain();

        do_reset();
        for (int i = 0; i < 8; i++) send(1, 4'd0, 2'b11, 8'(i), 8'(i), 0, 4'(i));
        repeat (8) step();
        check("t3_issued", iss, 4);
        check("t3_in_ready_low", IN_READY, 0);
        check("t3_out_valid", OUT_VALID, 1);
        nrdy = 1'b1;
        send(1, 4'd0, 2'b11, 8'd9, 8'd9, 0, 4'd8);
        drain();

        for (int i = 0; i < 2000; i++) begin
            nv = $urandom_range(0, 1) == 1;
            nmode = $urandom_range(0, 3) != 0;
            ncmd = $urandom_range(0, 2) == 0 ? 4'(9 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            niv = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 2)) : 2'b11;
            na = 8'($urandom);
            nb = 8'($urandom);
            ncin = $urandom_range(0, 1) == 1;
            ntag = tag_ctr;
            nrdy = $urandom_range(0, 3) != 0;
            step();
            if (hs_in) tag_ctr++;
        end
        drain();

        nrdy = 1'b0;
        for (int i = 0; i < 3; i++) send(1, 4'd0, 2'b11, 8'(i + 1), 8'd1, 0, 4'(i));
        repeat (2) step();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            check("t6_no_stale", OUT_VALID, 0);
        end
        send(1, 4'd1, 2'b11, 8'd7, 8'd2, 0, 4'd9);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
